// File: rtl/encoder_4to2_seq_pkg.sv
// Shared types and helpers for the 4-to-2 sequential priority encoder.
// Purely declarative: no latency, no backpressure.
package enc_pkg;

    localparam int REQ_W = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot mask of a request index, used to retire the granted bit.
    function automatic logic [REQ_W-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [REQ_W-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/encoder_4to2_seq_if.sv
// Request/grant bundle between the request source and the index consumer.
// Optional err signal exists only when ENC_ONEHOT_ERR_EN is defined.
interface encoder_4to2_seq_if
    import enc_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic [REQ_W-1:0] d;
    logic             en;
    logic             ready;
    logic [IDX_W-1:0] y;
    logic             valid;
    logic [CNT_W-1:0] cnt;
`ifdef ENC_ONEHOT_ERR_EN
    logic             err;

    modport master (output d, en, ready, input  y, valid, cnt, err);
    modport slave  (input  d, en, ready, output y, valid, cnt, err);
`else
    modport master (output d, en, ready, input  y, valid, cnt);
    modport slave  (input  d, en, ready, output y, valid, cnt);
`endif

endinterface

// File: rtl/encoder_4to2_seq_prio_enc4.sv
// Combinational highest-set-bit encoder over four request lines.
// Zero latency; no backpressure. idx is 0 when no bit is set.
module prio_enc4
    import enc_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |req;
        if (req[3]) begin
            idx = 2'd3;
        end else if (req[2]) begin
            idx = 2'd2;
        end else if (req[1]) begin
            idx = 2'd1;
        end
    end

endmodule

// File: rtl/encoder_4to2_seq.sv
// Registered 4-to-2 priority encoder with pending latch; y/valid follow a capture by one edge.
// Backpressure: y held while valid & ~ready unless a higher bit arrives. Optional err via ENC_ONEHOT_ERR_EN.
module encoder_4to2_seq
    import enc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    encoder_4to2_seq_if.slave   bus
);

    state_t           state_q, state_d;
    logic [REQ_W-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant;
    logic [REQ_W-1:0] clr;
    logic [REQ_W-1:0] cap;
    logic [IDX_W-1:0] idx_nxt;
    logic             any_nxt;

    // ready only matters while a grant is actually on offer.
    assign grant = (state_q == BUSY) && bus.ready;
    assign clr   = grant  ? onehot(y_q) : '0;
    assign cap   = bus.en ? bus.d       : '0;

    // Capture is OR-ed in after the clear, so a same-bit race keeps the bit.
    assign pend_d = (pend_q & ~clr) | cap;

    prio_enc4 u_prio (
        .req (pend_d),
        .idx (idx_nxt),
        .any (any_nxt)
    );

    always_comb begin
        state_d = IDLE;
        y_d     = '0;
        cnt_d   = cnt_q;
        if (any_nxt) begin
            state_d = BUSY;
            y_d     = idx_nxt;
        end
        if (grant) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.valid = (state_q == BUSY);
    assign bus.cnt   = cnt_q;

`ifdef ENC_ONEHOT_ERR_EN
    logic err_q, err_d;

    // d & (d-1) is non-zero exactly when two or more bits are set.
    assign err_d = bus.en && (|(bus.d & (bus.d - 4'd1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_encoder_4to2_seq.sv
// Bench for encoder_4to2_seq: pending-set model compared every cycle, plus literal spot checks.
// Checks err as well when ENC_ONEHOT_ERR_EN is defined.
module tb_encoder_4to2_seq;

    logic clk;
    logic rst_n;

    encoder_4to2_seq_if #(.CNT_W(8)) bus8 ();
    encoder_4to2_seq_if #(.CNT_W(2)) bus2 ();

    encoder_4to2_seq #(.CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    encoder_4to2_seq #(.CNT_W(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    assign bus2.d     = bus8.d;
    assign bus2.en    = bus8.en;
    assign bus2.ready = bus8.ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a set of pending request numbers; output is the largest member.
    bit mp [4];
    int my;
    bit mv;
    int mcnt;
    bit merr;

    always @(posedge clk or negedge rst_n) begin : model
        bit np [4];
        int hi;
        int ones;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) mp[k] <= 1'b0;
            my   <= 0;
            mv   <= 1'b0;
            mcnt <= 0;
            merr <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) np[k] = mp[k];
            if (mv && bus8.ready) begin
                np[my] = 1'b0;
                mcnt  <= mcnt + 1;
            end
            ones = 0;
            if (bus8.en) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus8.d[k]) begin
                        np[k] = 1'b1;
                        ones++;
                    end
                end
            end
            hi = -1;
            for (int k = 0; k < 4; k++) if (np[k]) hi = k;
            for (int k = 0; k < 4; k++) mp[k] <= np[k];
            mv   <= (hi >= 0);
            my   <= (hi >= 0) ? hi : 0;
            merr <= (ones >= 2);
        end
    end

    always @(negedge clk) begin
        chk("cyc_valid", int'(bus8.valid), int'(mv));
        chk("cyc_y",     int'(bus8.y),     my);
        chk("cyc_cnt8",  int'(bus8.cnt),   mcnt % 256);
        chk("cyc_cnt2",  int'(bus2.cnt),   mcnt % 4);
`ifdef ENC_ONEHOT_ERR_EN
        chk("cyc_err",   int'(bus8.err),   int'(merr));
`endif
    end

    task automatic step(input logic [3:0] d, input logic en, input logic rdy);
        bus8.d     = d;
        bus8.en    = en;
        bus8.ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    int cnt2_exp [5];

    initial begin
        cnt2_exp[0] = 1; cnt2_exp[1] = 2; cnt2_exp[2] = 3; cnt2_exp[3] = 0; cnt2_exp[4] = 1;
        rst_n      = 1'b0;
        bus8.d     = 4'b0000;
        bus8.en    = 1'b0;
        bus8.ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_y", int'(bus8.y), 0);
        chk("rst_valid", int'(bus8.valid), 0);
        chk("rst_cnt", int'(bus8.cnt), 0);
        rst_n = 1'b1;

        // Single request
        step(4'b0100, 1'b1, 1'b1);
        chk("single_y", int'(bus8.y), 2);
        chk("single_valid", int'(bus8.valid), 1);
        step(4'b0000, 1'b0, 1'b1);
        chk("single_done_valid", int'(bus8.valid), 0);
        chk("single_cnt", int'(bus8.cnt), 1);

        // Drain all four, order 3,2,1,0
        step(4'b1111, 1'b1, 1'b1);
        chk("drain_y0", int'(bus8.y), 3);
        step(4'b0000, 1'b0, 1'b1);
        chk("drain_y1", int'(bus8.y), 2);
        step(4'b0000, 1'b0, 1'b1);
        chk("drain_y2", int'(bus8.y), 1);
        step(4'b0000, 1'b0, 1'b1);
        chk("drain_y3", int'(bus8.y), 0);
        chk("drain_v3", int'(bus8.valid), 1);
        step(4'b0000, 1'b0, 1'b1);
        chk("drain_end_valid", int'(bus8.valid), 0);
        chk("drain_cnt", int'(bus8.cnt), 5);

        // Backpressure and pre-emption
        step(4'b0010, 1'b1, 1'b0);
        chk("bp_y", int'(bus8.y), 1);
        step(4'b0000, 1'b0, 1'b0);
        chk("bp_hold_y", int'(bus8.y), 1);
        step(4'b1000, 1'b1, 1'b0);
        chk("preempt_y", int'(bus8.y), 3);
        step(4'b0000, 1'b0, 1'b1);
        chk("preempt_next_y", int'(bus8.y), 1);
        chk("preempt_cnt", int'(bus8.cnt), 6);
        step(4'b0000, 1'b0, 1'b1);
        chk("preempt_end_valid", int'(bus8.valid), 0);

        // Same-bit race: clear and capture of bit 1 on one edge
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b1);
        chk("race_y", int'(bus8.y), 1);
        chk("race_valid", int'(bus8.valid), 1);
        chk("race_cnt", int'(bus8.cnt), 8);
        step(4'b0000, 1'b0, 1'b1);
        chk("race_end_cnt", int'(bus8.cnt), 9);

        // en=0 ignores d; ready while idle does not count
        step(4'b1111, 1'b0, 1'b1);
        chk("en0_valid", int'(bus8.valid), 0);
        chk("idle_ready_cnt", int'(bus8.cnt), 9);

        // Asynchronous reset mid-burst
        step(4'b1010, 1'b1, 1'b0);
        chk("pre_rst_y", int'(bus8.y), 3);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_y", int'(bus8.y), 0);
        chk("async_rst_valid", int'(bus8.valid), 0);
        chk("async_rst_cnt", int'(bus8.cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 1'b0, 1'b1);
        chk("post_rst_valid", int'(bus8.valid), 0);

        // Narrow counter wraps: 1,2,3,0,1
        step(4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 1'b1, 1'b1);
            chk($sformatf("cnt2_wrap%0d", i), int'(bus2.cnt), cnt2_exp[i]);
        end
        step(4'b0000, 1'b0, 1'b1);
        chk("cnt2_end_valid", int'(bus8.valid), 0);

        // Multi-hot capture
        step(4'b0110, 1'b1, 1'b0);
        chk("mh_y", int'(bus8.y), 2);
`ifdef ENC_ONEHOT_ERR_EN
        chk("err_multi", int'(bus8.err), 1);
`endif
        step(4'b0000, 1'b0, 1'b0);
`ifdef ENC_ONEHOT_ERR_EN
        chk("err_drop", int'(bus8.err), 0);
`endif
        step(4'b0100, 1'b1, 1'b0);
`ifdef ENC_ONEHOT_ERR_EN
        chk("err_single", int'(bus8.err), 0);
`endif
        step(4'b0000, 1'b0, 1'b1);
        chk("mh_next_y", int'(bus8.y), 1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        chk("final_valid", int'(bus8.valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
